eep_host_arb: RTL and testbench

EEP_HOST_ARB -- requirements
Module: eep_host_arb

---
 rtl/eep_host_arb.sv | 202 ++++++++++++++++++++
 tb/tb_eep_host_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eep_host_arb.sv
// Shared EEPROM-array arbiter between the CPU and the host image loader.
// A three-state FSM (IDLE/ACCESS/RESP) serves one requester at a time with
// a fixed two-cycle request-to-ack latency. Contention is resolved round-robin,
// and the CPU is held off while the host owns the lock. The block also tracks
// whether the CPU has modified the array and raises a save request once the
// CPU has been quiet for SAVE_DELAY cycles.
module eep_host_arb #(
  parameter int          EEP_SIZE   = 512,
  parameter int          ADDR_W     = 10,
  parameter logic [15:0] SAVE_DELAY = 16'd50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  input  logic              host_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              dirty,
  output logic              save_req,
  input  logic              dirty_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Array size expressed in the address width plus one bit so that a
  // full-range array (EEP_SIZE == 2**ADDR_W) still compares correctly.
  localparam logic [ADDR_W:0] EEP_LIMIT = (ADDR_W + 1)'(EEP_SIZE);

  state_t            state;
  state_t            state_next;

  // Arbitration results for the current cycle.
  logic              cpu_elig;
  logic              host_elig;
  logic              start_p0;
  logic              pick_host_p0;

  // Transaction latched at grant time and carried through ACCESS/RESP.
  logic              grant_host_p1;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [7:0]        wdata_p1;
  logic              last_host;

  // Response-side signals.
  logic              in_range_p1;
  logic              resp_p2;
  logic [7:0]        rd_val_p2;
  logic              cpu_wr_ack;
  logic [7:0]        cpu_rdata_q;
  logic [7:0]        host_rdata_q;

  // Dirty / save tracking.
  logic              dirty_q;
  logic              save_hold;
  logic [15:0]       save_cnt;

  // Address falls inside the physical array.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < EEP_LIMIT);
  endfunction

  // Saturating decrement: the counter parks at zero instead of wrapping.
  function automatic logic [15:0] sat_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : (v - 16'd1);
  endfunction

  // Stage 0: request eligibility and round-robin winner selection.
  always_comb begin
    cpu_elig     = cpu_req & ~host_lock;
    host_elig    = host_req;
    start_p0     = cpu_elig | host_elig;
    pick_host_p0 = host_elig;
    if (cpu_elig && host_elig) begin
      pick_host_p0 = ~last_host;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_p0) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, direction and round-robin pointer captured when a request wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_host_p1 <= 1'b0;
      we_p1         <= 1'b0;
      last_host     <= 1'b0;
    end else if (state == IDLE && start_p0) begin
      grant_host_p1 <= pick_host_p0;
      we_p1         <= pick_host_p0 ? host_we : cpu_we;
      last_host     <= pick_host_p0;
    end
  end

  // Address and write data of the winning request (data path, no reset).
  always_ff @(posedge clk) begin
    if (state == IDLE && start_p0) begin
      addr_p1  <= pick_host_p0 ? host_addr : cpu_addr;
      wdata_p1 <= pick_host_p0 ? host_wdata : cpu_wdata;
    end
  end

  // Stage 1: drive the array; rst gates mem_we so an aborted write never lands.
  always_comb begin
    in_range_p1 = in_range(addr_p1);
    mem_addr    = addr_p1;
    mem_wdata   = wdata_p1;
    mem_we      = (state == ACCESS) & we_p1 & in_range_p1 & ~rst;
  end

  // Stage 2: ack pulse and read data; reads beyond the array return 8'hFF.
  always_comb begin
    resp_p2    = (state == RESP) & ~rst;
    cpu_ack    = resp_p2 & ~grant_host_p1;
    host_ack   = resp_p2 & grant_host_p1;
    rd_val_p2  = in_range_p1 ? mem_rdata : 8'hFF;
    cpu_rdata  = (cpu_ack & ~we_p1) ? rd_val_p2 : cpu_rdata_q;
    host_rdata = (host_ack & ~we_p1) ? rd_val_p2 : host_rdata_q;
    cpu_wr_ack = cpu_ack & we_p1 & in_range_p1;
  end

  // Hold the last read value of each requester between acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q  <= 8'h00;
      host_rdata_q <= 8'h00;
    end else begin
      if (cpu_ack && !we_p1) cpu_rdata_q <= rd_val_p2;
      if (host_ack && !we_p1) host_rdata_q <= rd_val_p2;
    end
  end

  // Dirty flag, quiet-time counter and sticky save request.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q   <= 1'b0;
      save_hold <= 1'b0;
      save_cnt  <= 16'd0;
    end else begin
      // A fresh CPU write must not be lost to a save that just finished.
      if (cpu_wr_ack) begin
        dirty_q <= 1'b1;
      end else if (dirty_clr) begin
        dirty_q <= 1'b0;
      end

      if (cpu_wr_ack) begin
        save_cnt <= SAVE_DELAY;
      end else if (dirty_q) begin
        save_cnt <= sat_dec(save_cnt);
      end

      // Once raised, only a completed save drops the request.
      if (dirty_clr) begin
        save_hold <= 1'b0;
      end else if (dirty_q && save_cnt == 16'd0) begin
        save_hold <= 1'b1;
      end
    end
  end

  // The request is visible in the same cycle the counter reaches zero.
  always_comb begin
    dirty    = dirty_q;
    save_req = save_hold | (dirty_q & (save_cnt == 16'd0));
  end

endmodule

// File: tb/tb_eep_host_arb.sv
// Directed testbench for eep_host_arb with a small synchronous-read array model.
module tb_eep_host_arb;

  localparam int ADDR_W   = 10;
  localparam int EEP_SIZE = 512;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;
  logic [7:0]        host_rdata;
  logic              host_lock;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              dirty, save_req, dirty_clr;

  int checks;
  int failures;

  logic [7:0] mem [0:EEP_SIZE-1];

  eep_host_arb #(
    .EEP_SIZE  (EEP_SIZE),
    .ADDR_W    (ADDR_W),
    .SAVE_DELAY(16'd8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .host_lock (host_lock),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dirty     (dirty),
    .save_req  (save_req),
    .dirty_clr (dirty_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: write on the edge, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_we && mem_addr < EEP_SIZE) mem[mem_addr[8:0]] <= mem_wdata;
    mem_rdata <= (mem_addr < EEP_SIZE) ? mem[mem_addr[8:0]] : 8'h00;
  end

  // Global time guard.
  initial begin
    #2ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Single access by one requester; lat = negedges from request to ack (-1 if none).
  task automatic access(input logic is_host, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [7:0] d, output int lat, output logic [7:0] rd,
                        output logic saw_we);
    lat = -1; rd = 8'h00; saw_we = 1'b0;
    if (is_host) begin
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (mem_we) saw_we = 1'b1;
      if (is_host ? host_ack : cpu_ack) begin
        lat = k;
        rd  = is_host ? host_rdata : cpu_rdata;
        break;
      end
    end
    if (is_host) host_req = 1'b0; else cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); end
    checks++; if (host_ack !== 1'b0) begin failures++; $display("FAIL reset_host_ack got=%b exp=0", host_ack); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=00/00", cpu_rdata, host_rdata); end
    checks++; if (dirty !== 1'b0 || save_req !== 1'b0) begin failures++; $display("FAIL reset_dirty_save got=%b/%b exp=0/0", dirty, save_req); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    int lat; logic [7:0] rd; logic sw;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 8'hA5;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'h005 || mem_wdata !== 8'hA5) begin failures++; $display("FAIL wr_access got=we%b a%h d%h exp=we1 a005 dA5", mem_we, mem_addr, mem_wdata); end
    checks++; if (cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_early_ack got=%b exp=0", cpu_ack); end
    tick();
    checks++; if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL wr_ack got=ack%b we%b exp=ack1 we0", cpu_ack, mem_we); end
    checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL wr_rdata_hold got=%h exp=00", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    checks++; if (dirty !== 1'b1 || cpu_ack !== 1'b0) begin failures++; $display("FAIL wr_dirty got=dirty%b ack%b exp=1/0", dirty, cpu_ack); end
    access(1'b0, 1'b0, 10'h005, 8'h00, lat, rd, sw);
    checks++; if (lat !== 2 || rd !== 8'hA5 || sw !== 1'b0) begin failures++; $display("FAIL rd_back got=lat%0d rd%h we%b exp=lat2 rdA5 we0", lat, rd, sw); end
    checks++; if (cpu_rdata !== 8'hA5) begin failures++; $display("FAIL rd_hold got=%h exp=A5", cpu_rdata); end
  endtask

  task automatic test_round_robin();
    int host_at, cpu_at, lat; logic [7:0] rd; logic sw;
    for (int r = 0; r < 4; r++) begin
      // Before the last round a host-only access makes the host the last grant.
      if (r == 3) access(1'b1, 1'b0, 10'h003, 8'h00, lat, rd, sw);
      host_at = -1; cpu_at = -1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 10'h00A;
      cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 10'h014;
      for (int k = 1; k <= 20 && (host_at < 0 || cpu_at < 0); k++) begin
        tick();
        if (host_ack) begin host_at = k; host_req = 1'b0; end
        if (cpu_ack)  begin cpu_at  = k; cpu_req  = 1'b0; end
      end
      host_req = 1'b0; cpu_req = 1'b0;
      tick();
      checks++;
      if (r < 3) begin
        if (host_at !== 2 || cpu_at !== 5) begin failures++; $display("FAIL rr_round%0d got=host@%0d cpu@%0d exp=host@2 cpu@5", r, host_at, cpu_at); end
      end else begin
        if (cpu_at !== 2 || host_at !== 5) begin failures++; $display("FAIL rr_after_host got=host@%0d cpu@%0d exp=cpu@2 host@5", host_at, cpu_at); end
      end
    end
  endtask

  task automatic test_lock();
    int acks, lat; logic [7:0] rd; logic sw;
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    acks = 0;
    repeat (20) begin tick(); if (cpu_ack) acks++; end
    checks++; if (acks !== 0) begin failures++; $display("FAIL lock_stall got=%0d acks exp=0", acks); end
    host_lock = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (cpu_ack) begin lat = k; break; end
    end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lock_release got=lat%0d exp=lat2", lat); end
    cpu_req = 1'b0;
    tick();
    // Lock rising while a CPU access is already in ACCESS.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    tick();
    host_lock = 1'b1;
    tick();
    checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin failures++; $display("FAIL lock_inflight got=ack%b rd%h exp=ack1 rdA5", cpu_ack, cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    access(1'b1, 1'b0, 10'h005, 8'h00, lat, rd, sw);
    checks++; if (lat !== 2 || rd !== 8'hA5) begin failures++; $display("FAIL lock_host_rd got=lat%0d rd%h exp=lat2 rdA5", lat, rd); end
    host_lock = 1'b0;
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] rd; logic sw;
    access(1'b1, 1'b1, 10'h3FF, 8'h77, lat, rd, sw);
    checks++; if (sw !== 1'b0 || lat !== 2 || rd !== 8'hA5) begin failures++; $display("FAIL oor_write got=we%b lat%0d rd%h exp=we0 lat2 rdA5", sw, lat, rd); end
    access(1'b1, 1'b0, 10'h200, 8'h00, lat, rd, sw);
    checks++; if (sw !== 1'b0 || lat !== 2 || rd !== 8'hFF) begin failures++; $display("FAIL oor_read got=we%b lat%0d rd%h exp=we0 lat2 rdFF", sw, lat, rd); end
    checks++; if (host_rdata !== 8'hFF) begin failures++; $display("FAIL oor_hold got=%h exp=FF", host_rdata); end
  endtask

  task automatic test_dirty_save();
    int lat, rise; logic [7:0] rd; logic sw;
    checks++; if (save_req !== 1'b1 || dirty !== 1'b1) begin failures++; $display("FAIL save_pending got=req%b dirty%b exp=1/1", save_req, dirty); end
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    checks++; if (dirty !== 1'b0 || save_req !== 1'b0) begin failures++; $display("FAIL clr got=dirty%b req%b exp=0/0", dirty, save_req); end
    access(1'b1, 1'b1, 10'h007, 8'h42, lat, rd, sw);
    checks++; if (dirty !== 1'b0 || sw !== 1'b1) begin failures++; $display("FAIL host_wr_clean got=dirty%b we%b exp=0/1", dirty, sw); end
    // CPU write; access() returns one cycle after the ack cycle.
    access(1'b0, 1'b1, 10'h006, 8'h5A, lat, rd, sw);
    checks++; if (dirty !== 1'b1 || save_req !== 1'b0) begin failures++; $display("FAIL cpu_wr_dirty got=dirty%b req%b exp=1/0", dirty, save_req); end
    // Counter holds 8 in the cycle after the ack and reaches 0 eight decrements later.
    rise = -1;
    for (int i = 2; i <= 20; i++) begin
      tick();
      if (save_req) begin rise = i; break; end
    end
    checks++; if (rise !== 9) begin failures++; $display("FAIL save_delay got=rise@%0d exp=rise@9", rise); end
    access(1'b0, 1'b1, 10'h006, 8'h5B, lat, rd, sw);
    checks++; if (save_req !== 1'b1 || dirty !== 1'b1) begin failures++; $display("FAIL save_sticky got=req%b dirty%b exp=1/1", save_req, dirty); end
    // dirty_clr in the very cycle of a CPU write ack.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h008; cpu_wdata = 8'h11;
    tick();
    tick();
    checks++; if (cpu_ack !== 1'b1) begin failures++; $display("FAIL coinc_ack got=%b exp=1", cpu_ack); end
    dirty_clr = 1'b1; cpu_req = 1'b0;
    tick();
    dirty_clr = 1'b0;
    checks++; if (dirty !== 1'b1 || save_req !== 1'b0) begin failures++; $display("FAIL coinc_set_wins got=dirty%b req%b exp=1/0", dirty, save_req); end
  endtask

  task automatic test_reset_abort();
    int host_at, cpu_at; logic [7:0] hrd;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'h009; host_wdata = 8'h3C;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || host_ack !== 1'b0) begin failures++; $display("FAIL abort_we got=we%b ack%b exp=0/0", mem_we, host_ack); end
    host_req = 1'b0;
    tick();
    checks++; if (host_ack !== 1'b0 || cpu_ack !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL abort_acks got=h%b c%b we%b exp=000", host_ack, cpu_ack, mem_we); end
    checks++; if (dirty !== 1'b0 || save_req !== 1'b0 || cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin failures++; $display("FAIL abort_outputs got=d%b s%b c%h h%h exp=0 0 00 00", dirty, save_req, cpu_rdata, host_rdata); end
    rst = 1'b0;
    tick();
    // First contention after reset goes to the host; the aborted write never landed.
    host_at = -1; cpu_at = -1; hrd = 8'hEE;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h009;
    cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 10'h009;
    for (int k = 1; k <= 20 && (host_at < 0 || cpu_at < 0); k++) begin
      tick();
      if (host_ack) begin host_at = k; hrd = host_rdata; host_req = 1'b0; end
      if (cpu_ack)  begin cpu_at  = k; cpu_req  = 1'b0; end
    end
    host_req = 1'b0; cpu_req = 1'b0;
    tick();
    checks++; if (host_at !== 2 || cpu_at !== 5) begin failures++; $display("FAIL post_reset_rr got=host@%0d cpu@%0d exp=host@2 cpu@5", host_at, cpu_at); end
    checks++; if (hrd !== 8'h00) begin failures++; $display("FAIL abort_no_write got=%h exp=00", hrd); end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < EEP_SIZE; i++) mem[i] = 8'h00;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
    host_lock = 1'b0; dirty_clr = 1'b0;
    test_reset();
    test_cpu_write();
    test_round_robin();
    test_lock();
    test_out_of_range();
    test_dirty_save();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
